// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, one full-subtractor step per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to build the signed-overflow flag; otherwise ovf is tied to 0.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t state_reg, state_next;

   logic [WIDTH-1:0] a_sh_reg, b_sh_reg, res_sh_reg, res_next;
   logic [WIDTH-1:0] diff_reg;
   logic [CW-1:0]    cnt_reg;
   logic             br_reg, br_next, d_bit;
   logic             busy_reg, done_reg, bout_reg;
   logic             last_step;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (cnt_reg == LAST) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Full-subtractor cell on the operand LSBs and the stored borrow
   always_comb begin
      d_bit     = a_sh_reg[0] ^ b_sh_reg[0] ^ br_reg;
      br_next   = (~a_sh_reg[0] & b_sh_reg[0]) | (~(a_sh_reg[0] ^ b_sh_reg[0]) & br_reg);
      res_next  = {d_bit, res_sh_reg[WIDTH-1:1]};
      last_step = (state_reg == RUN) && (cnt_reg == LAST);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh_reg   <= '0;
         b_sh_reg   <= '0;
         res_sh_reg <= '0;
         br_reg     <= 1'b0;
         cnt_reg    <= '0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
         diff_reg   <= '0;
         bout_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  a_sh_reg <= a;
                  b_sh_reg <= b;
                  br_reg   <= bin;
                  cnt_reg  <= '0;
                  busy_reg <= 1'b1;
               end
            end
            RUN: begin
               a_sh_reg   <= a_sh_reg >> 1;
               b_sh_reg   <= b_sh_reg >> 1;
               res_sh_reg <= res_next;
               br_reg     <= br_next;
               cnt_reg    <= cnt_reg + 1'b1;
               if (last_step) begin
                  diff_reg <= res_next;
                  bout_reg <= br_next;
                  busy_reg <= 1'b0;
                  done_reg <= 1'b1;
               end
            end
            DONE:    done_reg <= 1'b0;
            default: done_reg <= 1'b0;
         endcase
      end
   end

   assign busy = busy_reg;
   assign done = done_reg;
   assign diff = diff_reg;
   assign bout = bout_reg;

`ifdef SERIAL_SUB_OVF_EN
   // Operand sign bits are shifted out during the run, so keep copies
   logic a_msb_reg, b_msb_reg, ovf_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_msb_reg <= 1'b0;
         b_msb_reg <= 1'b0;
         ovf_reg   <= 1'b0;
      end else begin
         if (state_reg == IDLE && start) begin
            a_msb_reg <= a[WIDTH-1];
            b_msb_reg <= b[WIDTH-1];
         end
         if (last_step)
            ovf_reg <= (a_msb_reg ^ b_msb_reg) & (d_bit ^ a_msb_reg);
      end
   end

   assign ovf = ovf_reg;
`else
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: WIDTH=8 vectors plus an exhaustive WIDTH=3 back-to-back sweep.
// Overflow expectations follow SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       start8, bin8, busy8, done8, bout8, ovf8;
   logic [7:0] a8, b8, diff8;
   logic       start3, bin3, busy3, done3, bout3, ovf3;
   logic [2:0] a3, b3, diff3;

`ifdef SERIAL_SUB_OVF_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif

   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc_cnt  = 0;
   logic [7:0] last_diff8;

   serial_subtractor #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
      .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
   );

   serial_subtractor #(.WIDTH(3)) u3 (
      .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .bin(bin3),
      .busy(busy3), .done(done3), .diff(diff3), .bout(bout3), .ovf(ovf3)
   );

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Starts from an IDLE, post-edge point and returns at the first IDLE cycle after done
   task automatic run8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic bv_in, input logic [7:0] ed, input logic eb, input logic eo);
      int cyc, busy_n;
      a8 = av; b8 = bv; bin8 = bv_in; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      chk({tag, "_hold"}, diff8, last_diff8);
      cyc = 0; busy_n = 0;
      while (!done8 && cyc < 20) begin
         if (busy8) busy_n++;
         @(posedge clk); #1;
         cyc++;
      end
      chk({tag, "_lat"}, cyc, 8);
      chk({tag, "_busy"}, busy_n, 8);
      chk({tag, "_busy_end"}, busy8, 0);
      chk({tag, "_diff"}, diff8, ed);
      chk({tag, "_bout"}, bout8, eb);
      chk({tag, "_ovf"}, ovf8, eo & OVF_ON);
      @(posedge clk); #1;
      chk({tag, "_pulse"}, done8, 0);
      last_diff8 = ed;
      $display("%s: %02h - %02h - %0d -> diff=%02h bout=%0d ovf=%0d", tag, av, bv, bv_in, diff8, bout8, ovf8);
   endtask

   task automatic count_done8(input string tag, input int cycles);
      int seen;
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         if (done8) seen++;
      end
      chk(tag, seen, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int         cyc, prev_done, v;
      logic [3:0] e3;
      rst = 1'b1; start8 = 1'b0; start3 = 1'b0;
      a8 = '0; b8 = '0; bin8 = 1'b0; a3 = '0; b3 = '0; bin3 = 1'b0;
      last_diff8 = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy8, 0);
      chk("rst_done", done8, 0);
      chk("rst_diff", diff8, 0);
      chk("rst_bout", bout8, 0);
      chk("rst_ovf", ovf8, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      run8("sub_05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
      run8("sub_00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
      run8("sub_10_0F_b", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
      run8("sub_80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);

      // A second start arriving mid-run must be dropped
      a8 = 8'h09; b8 = 8'h04; bin8 = 1'b0; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      cyc = 0;
      while (!done8 && cyc < 20) begin @(posedge clk); #1; cyc++; end
      chk("ign_lat", cyc, 5);
      chk("ign_diff", diff8, 8'h05);
      chk("ign_bout", bout8, 0);
      count_done8("ign_extra_done", 20);
      chk("ign_diff_held", diff8, 8'h05);
      $display("ignore: 09 - 04 with late start -> diff=%02h", diff8);

      // Reset after four bit steps aborts the run and clears the held result
      a8 = 8'hAA; b8 = 8'h55; bin8 = 1'b0; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      rst = 1'b1;
      #1;
      chk("abort_busy", busy8, 0);
      chk("abort_done", done8, 0);
      chk("abort_diff", diff8, 0);
      chk("abort_bout", bout8, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      count_done8("abort_no_done", 20);
      last_diff8 = 8'h00;
      $display("abort: AA - 55 reset mid-run -> busy=%0d diff=%02h", busy8, diff8);
      run8("sub_AA_55", 8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1);

      // Exhaustive WIDTH=3 sweep with start held high
      {a3, b3, bin3} = 7'd0;
      start3 = 1'b1;
      prev_done = 0;
      for (v = 0; v < 128; v++) begin
         cyc = 0;
         while (!busy3 && cyc < 10) begin @(posedge clk); #1; cyc++; end
         chk("x3_accept", busy3, 1);
         e3 = {1'b0, a3} - {1'b0, b3} - {3'b000, bin3};
         if (v < 127) {a3, b3, bin3} = 7'(v + 1);
         else start3 = 1'b0;
         cyc = 0;
         while (!done3 && cyc < 10) begin @(posedge clk); #1; cyc++; end
         chk($sformatf("x3_res_%0d", v), {bout3, diff3}, e3);
         if (v > 0) chk($sformatf("x3_space_%0d", v), cyc_cnt - prev_done, 5);
         prev_done = cyc_cnt;
         $display("x3 %0d: diff=%0d bout=%0d expected diff=%0d bout=%0d", v, diff3, bout3, e3[2:0], e3[3]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial WIDTH-bit subtractor that computes a − b − bin one bit per clock, LSB first, using a single full-subtractor cell with a registered borrow. It complements the combinational full adder in the arithmetic library. It serves area-constrained datapaths that can trade latency for logic. Operands are captured on a start handshake, and the result is reported with a one-cycle done pulse.

## Interface
- WIDTH, 8, operand and result width in bits; must be ≥ 2.

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- a  in  WIDTH  minuend, captured at the accepting edge
- b  in  WIDTH  subtrahend, captured at the accepting edge
- bin  in  1  borrow-in, captured at the accepting edge
- busy  out  1  high while a subtraction is in progress
- done  out  1  one-cycle pulse; result valid
- diff  out  WIDTH  result (a − b − bin) mod 2^WIDTH, registered
- bout  out  1  borrow-out, registered
- ovf  out  1  signed overflow, registered; only meaningful with SERIAL_SUB_OVF_EN

## Operation
- States:
  - IDLE → RUN on start=1.
  - RUN → DONE after WIDTH bit steps.
  - DONE → IDLE unconditionally.
- Accept (IDLE, start=1):
  - Load a and b into shift registers and bin into the borrow register.
  - Clear the bit counter to 0.
  - Set busy.
- RUN, per cycle, on bits a_i and b_i at the shift-register LSBs:
  - d_i = a_i ^ b_i ^ br
  - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)
  - Shift d_i into the MSB of the result shift register.
  - Shift the operand registers right and increment the counter.
- At the last bit step (counter = WIDTH−1):
  - Copy the result shift register, including the final d_i, to diff.
  - Copy br_next to bout.
  - Clear busy, set done, and go to DONE.
- DONE: clear done and go to IDLE.
- Output holding:
  - diff, bout and ovf update only at completion.
  - They hold the previous result throughout a new computation and until the next completion.
- start while in RUN or DONE is ignored. It is not queued, and the operands are not resampled.
- start held high continuously: a new operation is accepted in each IDLE cycle, giving back-to-back runs.
- Arithmetic:
  - diff = (a − b − bin) mod 2^WIDTH.
  - bout = 1 iff a < b + bin (unsigned).
  - ovf = (a[W−1] ^ b[W−1]) & (diff[W−1] ^ a[W−1]), evaluated on the captured operands.

## Timing
- Reset values (asynchronous, immediate on rst=1):
  - state=IDLE; busy=0, done=0, diff=0, bout=0, ovf=0.
  - Internal shift registers, borrow register and counter are all 0.
- Reset mid-operation: the run is aborted with no done pulse and the previous result is lost (diff, bout, ovf = 0).
- Latency, with E0 the accepting edge:
  - busy is high from E0 until E(WIDTH).
  - diff, bout and ovf update at E(WIDTH); done is high for the cycle between E(WIDTH) and E(WIDTH+1).
- Throughput: one result per WIDTH+2 cycles when start is held high.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- SERIAL_SUB_OVF_EN defined: the ovf register and its logic are built, and ovf is updated at completion per the formula above.
- Macro undefined: the ovf port still exists but is tied to constant 0, and no overflow logic is synthesised.

## Test plan
- WIDTH=8; a=0x05, b=0x03, bin=0, start for 1 cycle:
  - diff=0x02, bout=0.
  - done is high exactly in the cycle after the 8th edge following the accepting edge; busy is high for 8 cycles.
- a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1. Then a=0x10, b=0x0F, bin=1 → diff=0x00, bout=0.
- a=0x80, b=0x01, bin=0 → diff=0x7F, bout=0. ovf=1 with SERIAL_SUB_OVF_EN, ovf=0 without.
- Start with a=0x09, b=0x04. Two cycles later, pulse start with a=0xFF, b=0x00 → single done with diff=0x05; the second request is ignored.
- Assert rst after 4 bit steps of a=0xAA − 0x55:
  - busy, done, diff and bout go 0 immediately, and no done pulse follows.
  - A new start then yields a correct result.
- WIDTH=3 exhaustive: all 128 (a, b, bin) combinations compared against the reference model (a − b − bin) mod 8 and the borrow; start is held high to check back-to-back spacing of 5 cycles.
